// File: rtl/sal_bk_ctrl_pkg.sv
// Shared types and default widths for the per-bank DRAM controller.
package sal_bk_ctrl_pkg;

  localparam int unsigned RaWDef   = 16;
  localparam int unsigned CaWDef   = 10;
  localparam int unsigned IdWDef   = 4;
  localparam int unsigned LenWDef  = 4;
  localparam int unsigned SeqWDef  = 8;
  localparam int unsigned CntrWDef = 8;

  typedef logic [SeqWDef-1:0] seq_num_t;

  typedef enum logic [2:0] {
    StClosed,
    StActivating,
    StOpen,
    StPrecharging,
    StRefreshing
  } bank_state_e;

endpackage

// File: rtl/sal_bk_ctrl_timing_cntr.sv
// Intra-bank timing counter: loads on grant, counts down, saturates at zero.
module sal_bk_ctrl_timing_cntr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sal_bk_ctrl.sv
// Single-bank controller: one pending access, row state tracking and
// intra-bank timing gates for ACT/RD/WR/PRE/REF requests.
module sal_bk_ctrl
  import sal_bk_ctrl_pkg::*;
#(
  parameter int unsigned RA_W   = RaWDef,
  parameter int unsigned CA_W   = CaWDef,
  parameter int unsigned ID_W   = IdWDef,
  parameter int unsigned LEN_W  = LenWDef,
  parameter int unsigned SEQ_W  = SeqWDef,
  parameter int unsigned CNTR_W = CntrWDef
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNTR_W-1:0] t_rcd_m1,
  input  logic [CNTR_W-1:0] t_rp_m1,
  input  logic [CNTR_W-1:0] t_ras_m1,
  input  logic [CNTR_W-1:0] t_rtp_m1,
  input  logic [CNTR_W-1:0] t_wtp_m1,
  input  logic [CNTR_W-1:0] t_rfc_m1,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wr_i,
  input  logic [RA_W-1:0]   req_ra_i,
  input  logic [CA_W-1:0]   req_ca_i,
  input  logic [ID_W-1:0]   req_id_i,
  input  logic [LEN_W-1:0]  req_len_i,
  input  logic [SEQ_W-1:0]  req_seq_i,
  input  logic              ref_req_i,
  output logic              ref_ack_o,
  output logic              act_req_o,
  output logic              rd_req_o,
  output logic              wr_req_o,
  output logic              pre_req_o,
  output logic              ref_req_o,
  output logic [RA_W-1:0]   ra_o,
  output logic [CA_W-1:0]   ca_o,
  output logic [ID_W-1:0]   id_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [SEQ_W-1:0]  seq_o,
  input  logic              act_gnt_i,
  input  logic              rd_gnt_i,
  input  logic              wr_gnt_i,
  input  logic              pre_gnt_i,
  input  logic              ref_gnt_i
);

  bank_state_e state_q, state_d;

  logic              pend_valid_q;
  logic              pend_wr_q;
  logic [RA_W-1:0]   pend_ra_q;
  logic [CA_W-1:0]   pend_ca_q;
  logic [ID_W-1:0]   pend_id_q;
  logic [LEN_W-1:0]  pend_len_q;
  logic [SEQ_W-1:0]  pend_seq_q;
  logic [RA_W-1:0]   open_row_q;

  logic act_fire, rd_fire, wr_fire, pre_fire, ref_fire, accept;
  logic row_miss, pre_ok;
  logic [CNTR_W-1:0] rcd_cnt, rp_cnt, ras_cnt, rtp_cnt, wtp_cnt, rfc_cnt;
  logic rcd_last, rp_last, rfc_last;

  // Grants are qualified by our own request so stray grants have no effect.
  assign act_fire = act_req_o & act_gnt_i;
  assign rd_fire  = rd_req_o & rd_gnt_i;
  assign wr_fire  = wr_req_o & wr_gnt_i;
  assign pre_fire = pre_req_o & pre_gnt_i;
  assign ref_fire = ref_req_o & ref_gnt_i;

  assign req_ready_o = ~pend_valid_q | rd_fire | wr_fire;
  assign accept      = req_valid_i & req_ready_o;
  assign ref_ack_o   = ref_fire;

  // Waiting states leave one cycle early so the follow-on command lands at t+X.
  assign rcd_last = (rcd_cnt[CNTR_W-1:1] == '0);
  assign rp_last  = (rp_cnt[CNTR_W-1:1] == '0);
  assign rfc_last = (rfc_cnt[CNTR_W-1:1] == '0);

  assign row_miss = pend_valid_q & (pend_ra_q != open_row_q);
  assign pre_ok   = (ras_cnt == '0) & (rtp_cnt == '0) & (wtp_cnt == '0);

  sal_bk_ctrl_timing_cntr #(.W(CNTR_W)) u_rcd (
    .clk(clk), .rst_n(rst_n), .load(act_fire), .load_val(t_rcd_m1), .cnt(rcd_cnt)
  );
  sal_bk_ctrl_timing_cntr #(.W(CNTR_W)) u_rp (
    .clk(clk), .rst_n(rst_n), .load(pre_fire), .load_val(t_rp_m1), .cnt(rp_cnt)
  );
  sal_bk_ctrl_timing_cntr #(.W(CNTR_W)) u_ras (
    .clk(clk), .rst_n(rst_n), .load(act_fire), .load_val(t_ras_m1), .cnt(ras_cnt)
  );
  sal_bk_ctrl_timing_cntr #(.W(CNTR_W)) u_rtp (
    .clk(clk), .rst_n(rst_n), .load(rd_fire), .load_val(t_rtp_m1), .cnt(rtp_cnt)
  );
  sal_bk_ctrl_timing_cntr #(.W(CNTR_W)) u_wtp (
    .clk(clk), .rst_n(rst_n), .load(wr_fire), .load_val(t_wtp_m1), .cnt(wtp_cnt)
  );
  sal_bk_ctrl_timing_cntr #(.W(CNTR_W)) u_rfc (
    .clk(clk), .rst_n(rst_n), .load(ref_fire), .load_val(t_rfc_m1), .cnt(rfc_cnt)
  );

  always_comb begin
    state_d   = state_q;
    act_req_o = 1'b0;
    rd_req_o  = 1'b0;
    wr_req_o  = 1'b0;
    pre_req_o = 1'b0;
    ref_req_o = 1'b0;
    unique case (state_q)
      StClosed: begin
        if (ref_req_i) begin
          ref_req_o = 1'b1;
          if (ref_gnt_i && t_rfc_m1 != '0) state_d = StRefreshing;
        end else if (pend_valid_q) begin
          act_req_o = 1'b1;
          if (act_gnt_i) state_d = (t_rcd_m1 == '0) ? StOpen : StActivating;
        end
      end
      StActivating: if (rcd_last) state_d = StOpen;
      StOpen: begin
        if (ref_req_i || row_miss) begin
          pre_req_o = pre_ok;
          if (pre_ok && pre_gnt_i) state_d = (t_rp_m1 == '0) ? StClosed : StPrecharging;
        end else if (pend_valid_q) begin
          rd_req_o = ~pend_wr_q;
          wr_req_o = pend_wr_q;
        end
      end
      StPrecharging: if (rp_last) state_d = StClosed;
      StRefreshing:  if (rfc_last) state_d = StClosed;
      default:       state_d = StClosed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StClosed;
      open_row_q <= '0;
    end else begin
      state_q <= state_d;
      if (act_fire) open_row_q <= pend_ra_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_ra_q    <= '0;
      pend_ca_q    <= '0;
      pend_id_q    <= '0;
      pend_len_q   <= '0;
      pend_seq_q   <= '0;
    end else if (accept) begin
      pend_valid_q <= 1'b1;
      pend_wr_q    <= req_wr_i;
      pend_ra_q    <= req_ra_i;
      pend_ca_q    <= req_ca_i;
      pend_id_q    <= req_id_i;
      pend_len_q   <= req_len_i;
      pend_seq_q   <= req_seq_i;
    end else if (rd_fire || wr_fire) begin
      pend_valid_q <= 1'b0;
    end
  end

  assign ra_o  = pend_ra_q;
  assign ca_o  = pend_ca_q;
  assign id_o  = pend_id_q;
  assign len_o = pend_len_q;
  assign seq_o = pend_seq_q;

endmodule

// File: doc/sal_bk_ctrl.md
# sal_bk_ctrl

Per-bank DRAM controller for one bank. It sits between the request decoder/refresh controller (upstream) and the channel scheduler (downstream). It holds one pending access and tracks the bank's row state. It raises exactly one of ACT/RD/WR/PRE/REF requests toward the scheduler once the intra-bank timing for that command is met. The scheduler handles all inter-bank timing and arbitration; this block handles intra-bank timing only.

## Interface
Parameters:
- RA_W, 16, row address width
- CA_W, 10, column address width
- ID_W, 4, transaction id width
- LEN_W, 4, burst length field width
- SEQ_W, 8, global sequence number width (must match scheduler)
- CNTR_W, 8, timing counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- t_rcd_m1, t_rp_m1, t_ras_m1, t_rtp_m1, t_wtp_m1, t_rfc_m1  in  CNTR_W each  timing value minus one; quasi-static
- req_valid_i  in  1  access request valid
- req_ready_o  out  1  access request accepted when valid&ready
- req_wr_i  in  1  1 = write, 0 = read
- req_ra_i / req_ca_i / req_id_i / req_len_i / req_seq_i  in  RA_W/CA_W/ID_W/LEN_W/SEQ_W  request fields
- ref_req_i  in  1  refresh needed (level, held until ref_ack_o)
- ref_ack_o  out  1  one-cycle pulse when REF is granted
- act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o  out  1 each  command requests to scheduler; at most one high
- ra_o / ca_o / id_o / len_o / seq_o  out  RA_W/CA_W/ID_W/LEN_W/SEQ_W  fields of the pending request
- act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i, ref_gnt_i  in  1 each  grants from scheduler; combinational response to this cycle's requests

## Operation
- One-entry pending buffer. req_ready_o = ~pend_valid | rd_gnt_i | wr_gnt_i, so the buffer refills in the same cycle a RD/WR is granted.
- FSM states and transitions:
  - CLOSED:
    - if ref_req_i: ref_req_o; on ref_gnt_i -> REFRESHING, load rfc.
    - else if pend_valid: act_req_o with ra_o = pend ra; on act_gnt_i -> ACTIVATING, open_row <= pend ra, load rcd and ras.
  - ACTIVATING: when rcd met -> OPEN. No requests raised in this state.
  - OPEN:
    - if ref_req_i, or pend_valid with pend ra != open_row: pre_req_o when ras, rtp and wtp are all met; on pre_gnt_i -> PRECHARGING, load rp.
    - else if pend_valid (row hit): rd_req_o or wr_req_o per pend wr, with no timing gate. On rd_gnt_i, load rtp; on wr_gnt_i, load wtp; either clears pend (unless refilled).
  - PRECHARGING: when rp met -> CLOSED.
  - REFRESHING: when rfc met -> CLOSED.
- Priority: refresh beats a pending access. An open-row hit is not served while ref_req_i is high.
- A grant whose request is low is ignored; the verification bench asserts this never happens.
- ref_ack_o = ref_req_o & ref_gnt_i.
- Reset values:
  - all *_req_o, ref_ack_o = 0; req_ready_o = 1
  - field outputs = 0
  - FSM = CLOSED; counters = 0; pend_valid = 0
- Reset mid-operation aborts any state immediately. No command is issued in the following cycle unless a request is accepted.

## Timing
- Counter: loaded with X_m1 on the grant cycle t, decrements by one per cycle, saturates at 0. "Met" means the counter is 0. The next dependent command can be requested at cycle t+X.
- A state transition on "met" takes one cycle. For example, act_gnt at t gives OPEN at t+X_rcd and rd_req_o high in that same cycle.
- A request arriving while CLOSED: act_req_o is high the cycle after acceptance (registered pend).
- Outputs are registered-state functions. *_req_o and fields are combinational from registered state and ref_req_i; there is no gnt→req combinational path.
- Row-hit streaming: one RD/WR per cycle is possible if the scheduler grants.

## Structure
- Shared package:
  - bank state enum (CLOSED, ACTIVATING, OPEN, PRECHARGING, REFRESHING)
  - seq_num_t typedef
  - width constants
- Sub-module: the existing SAL_TIMING_CNTR, instantiated six times (rcd, rp, ras, rtp, wtp, rfc).

## Test plan
- Closed-bank read, t_rcd_m1=3: accept at cycle 0; act_req at 1; act_gnt at 1; rd_req at 5; rd_gnt → req_ready stays high and pend clears.
- Row hit: 4 back-to-back reads to the same row with grants every cycle → 4 consecutive rd_gnt, no ACT/PRE.
- Row conflict, t_ras_m1=9, act_gnt at 1: pre_req_o no earlier than cycle 11. After pre_gnt at 11 with t_rp_m1=2, act_req at 14.
- Refresh while OPEN with a pending hit: PRE, then REF precede the RD. ref_ack pulses once. CLOSED occurs t_rfc cycles after ref_gnt, then ACT and RD.
- Write then row miss, t_wtp_m1=5: pre_req_o not before 6 cycles after wr_gnt.
- rst_n low during ACTIVATING → the next cycle shows CLOSED, all requests low, req_ready high.
